int_to_rec_fn_pipe: RTL and testbench

INT_TO_REC_FN_PIPE -- requirements
Module: int_to_rec_fn_pipe

---
 rtl/int_to_rec_fn_pipe_if.sv | 34 +++
 rtl/int_to_rec_fn_pipe.sv | 138 +++++++++++++
 tb/tb_int_to_rec_fn_pipe.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_to_rec_fn_pipe_if.sv
// Handshake and data bundle for the integer-to-recoded-float pipeline.
// The producer/consumer side uses master; the converter uses slave.
interface int_to_rec_fn_pipe_if #(
    parameter int INT_W = 64,
    parameter int EXP_W = 11,
    parameter int SIG_W = 53,
    parameter int TAG_W = 4
);
    logic                   io_in_valid;
    logic                   io_in_ready;
    logic                   io_in_signedIn;
    logic [INT_W-1:0]       io_in_bits;
    logic [2:0]             io_in_roundingMode;
    logic [TAG_W-1:0]       io_in_tag;
    logic                   io_out_valid;
    logic                   io_out_ready;
    logic [EXP_W+SIG_W:0]   io_out_bits;
    logic [4:0]             io_out_exceptionFlags;
    logic [TAG_W-1:0]       io_out_tag;

    modport master (
        output io_in_valid, io_in_signedIn, io_in_bits, io_in_roundingMode,
               io_in_tag, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits, io_out_exceptionFlags,
               io_out_tag
    );

    modport slave (
        input  io_in_valid, io_in_signedIn, io_in_bits, io_in_roundingMode,
               io_in_tag, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits, io_out_exceptionFlags,
               io_out_tag
    );
endinterface

// File: rtl/int_to_rec_fn_pipe.sv
// Two-stage integer to recoded floating-point converter.
// Stage 1 captures sign, magnitude and leading-zero count; stage 2 rounds into the output register.
module int_to_rec_fn_pipe #(
    parameter int INT_W = 64,
    parameter int EXP_W = 11,
    parameter int SIG_W = 53,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    int_to_rec_fn_pipe_if.slave  io
);
    localparam int LZ_W  = $clog2(INT_W);
    localparam int EXT_W = INT_W + SIG_W;
    localparam int OUT_W = EXP_W + SIG_W + 1;
    localparam logic [EXP_W:0] EXP_BASE = (EXP_W+1)'((1 << EXP_W) + INT_W - 1);

    logic               s1_valid_q, s1_valid_d;
    logic               sign_q, sign_d;
    logic [INT_W-1:0]   mag_q, mag_d;
    logic [LZ_W-1:0]    lz_q, lz_d;
    logic [2:0]         rm_q, rm_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_bits_q, out_bits_d;
    logic [4:0]         out_flags_q, out_flags_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;

    logic               s1_load, s2_load;
    logic               sign_in;
    logic [INT_W-1:0]   mag_in;
    logic [LZ_W-1:0]    lz_in;

    logic [INT_W-1:0]   norm;
    logic [EXT_W-1:0]   ext;
    logic [SIG_W-2:0]   fract_raw;
    logic               guard, sticky, inexact, round_up;
    logic [SIG_W-1:0]   rounded;
    logic [EXP_W:0]     exp_rec;
    logic [OUT_W-1:0]   rec;

    // Each stage refills when empty or when its occupant moves on this cycle.
    assign s2_load        = ~out_valid_q | io.io_out_ready;
    assign s1_load        = ~s1_valid_q | s2_load;
    assign io.io_in_ready = s1_load;

    always_comb begin
        sign_in = io.io_in_signedIn & io.io_in_bits[INT_W-1];
        mag_in  = sign_in ? (~io.io_in_bits) + {{(INT_W-1){1'b0}}, 1'b1} : io.io_in_bits;
        lz_in   = '0;
        for (int i = 0; i < INT_W; i++) begin
            if (mag_in[i]) lz_in = LZ_W'(INT_W - 1 - i);
        end
    end

    // Padding below the normalised value lets one slice serve both INT_W >= SIG_W and INT_W < SIG_W.
    always_comb begin
        norm      = mag_q << lz_q;
        ext       = {norm[INT_W-2:0], {(SIG_W+1){1'b0}}};
        fract_raw = ext[EXT_W-1 -: SIG_W-1];
        guard     = ext[EXT_W-SIG_W];
        sticky    = |ext[EXT_W-SIG_W-1:0];
        inexact   = guard | sticky;
        case (rm_q)
            3'b001:  round_up = 1'b0;
            3'b010:  round_up = sign_q & inexact;
            3'b011:  round_up = ~sign_q & inexact;
            3'b100:  round_up = guard;
            default: round_up = guard & (sticky | fract_raw[0]);
        endcase
        rounded = {1'b0, fract_raw} + {{(SIG_W-1){1'b0}}, round_up};
        exp_rec = EXP_BASE - {{(EXP_W+1-LZ_W){1'b0}}, lz_q}
                  + {{EXP_W{1'b0}}, rounded[SIG_W-1]};
        rec     = (mag_q == '0) ? '0 : {sign_q, exp_rec, rounded[SIG_W-2:0]};
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        lz_d        = lz_q;
        rm_d        = rm_q;
        tag_d       = tag_q;
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        out_flags_d = out_flags_q;
        out_tag_d   = out_tag_q;
        if (s1_load) begin
            s1_valid_d = io.io_in_valid;
            if (io.io_in_valid) begin
                sign_d = sign_in;
                mag_d  = mag_in;
                lz_d   = lz_in;
                rm_d   = io.io_in_roundingMode;
                tag_d  = io.io_in_tag;
            end
        end
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_bits_d  = rec;
                out_flags_d = {4'b0000, inexact};
                out_tag_d   = tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            lz_q        <= '0;
            rm_q        <= '0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_flags_q <= '0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            lz_q        <= lz_d;
            rm_q        <= rm_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            out_flags_q <= out_flags_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign io.io_out_valid          = out_valid_q;
    assign io.io_out_bits           = out_bits_q;
    assign io.io_out_exceptionFlags = out_flags_q;
    assign io.io_out_tag            = out_tag_q;
endmodule

// File: tb/tb_int_to_rec_fn_pipe.sv
// Bench for int_to_rec_fn_pipe: directed corner values, a random stalled stream and
// reset-flush checks on a 64/11/53 instance and a 32/8/24 instance.
module tb_int_to_rec_fn_pipe;
    localparam int AI = 64, AE = 11, AS = 53;
    localparam int BI = 32, BE = 8,  BS = 24;
    localparam int TW = 4;

    typedef struct packed {
        logic [127:0] bits;
        logic [4:0]   flags;
        logic [TW-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n;

    int_to_rec_fn_pipe_if #(.INT_W(AI), .EXP_W(AE), .SIG_W(AS), .TAG_W(TW)) ia ();
    int_to_rec_fn_pipe_if #(.INT_W(BI), .EXP_W(BE), .SIG_W(BS), .TAG_W(TW)) ib ();

    int_to_rec_fn_pipe #(.INT_W(AI), .EXP_W(AE), .SIG_W(AS), .TAG_W(TW)) dut_a (
        .clk(clk), .reset_n(rst_a_n), .io(ia));
    int_to_rec_fn_pipe #(.INT_W(BI), .EXP_W(BE), .SIG_W(BS), .TAG_W(TW)) dut_b (
        .clk(clk), .reset_n(rst_b_n), .io(ib));

    int n_vec = 0;
    int n_err = 0;
    exp_t q_a[$];
    exp_t pend;
    logic prev_stall = 1'b0;
    logic [AE+AS:0] prev_bits;
    logic [4:0] prev_flags;
    logic [TW-1:0] prev_tag;
    int pops_a = 0;

    // Reference: locate the leading one, split off the discarded tail and compare it with one half ulp.
    function automatic logic [127:0] ref_rec(input int iw, input int ew, input int sw,
                                             input logic sgn_in, input logic [127:0] bits_in,
                                             input logic [2:0] rm, output logic inx);
        logic [127:0] ones, mask, bits, mag, kept, rem, half, res;
        logic sgn, up;
        int k, sh;
        ones = '1;
        mask = ones >> (128 - iw);
        bits = bits_in & mask;
        sgn  = sgn_in & bits[iw-1];
        mag  = sgn ? ((~bits + 128'd1) & mask) : bits;
        inx  = 1'b0;
        up   = 1'b0;
        if (mag == '0) return '0;
        k = 127;
        while (!mag[k]) k--;
        if (k > sw - 1) begin
            sh   = k - (sw - 1);
            kept = mag >> sh;
            rem  = mag & (ones >> (128 - sh));
            half = 128'd1 << (sh - 1);
            inx  = (rem != '0);
            case (rm)
                3'd1:    up = 1'b0;
                3'd2:    up = sgn && inx;
                3'd3:    up = !sgn && inx;
                3'd4:    up = (rem >= half);
                default: up = (rem > half) || ((rem == half) && kept[0]);
            endcase
        end else begin
            kept = mag << (sw - 1 - k);
        end
        kept = kept + 128'(up);
        if (kept == (128'd1 << sw)) begin
            kept = kept >> 1;
            k++;
        end
        res = 128'(sgn) << (ew + sw);
        res = res | (128'((1 << ew) + k) << (sw - 1));
        res = res | (kept - (128'd1 << (sw - 1)));
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s actual=%h required=%h", tag, obs, expv);
        end
    endtask

    // One cycle on instance A, entered and left at a falling edge with inputs already driven.
    task automatic cycle_a();
        exp_t e;
        #1;
        if (prev_stall) begin
            chk("hold_valid", 128'(ia.io_out_valid), 128'd1);
            chk("hold_bits",  128'(ia.io_out_bits), 128'(prev_bits));
            chk("hold_flags", 128'(ia.io_out_exceptionFlags), 128'(prev_flags));
            chk("hold_tag",   128'(ia.io_out_tag), 128'(prev_tag));
        end
        if (ia.io_out_ready) chk("in_ready_open", 128'(ia.io_in_ready), 128'd1);
        if (ia.io_out_valid && ia.io_out_ready) begin
            if (q_a.size() == 0) begin
                chk("spurious_out", 128'(ia.io_out_valid), 128'd0);
            end else begin
                e = q_a.pop_front();
                chk("out_bits",  128'(ia.io_out_bits), e.bits);
                chk("out_flags", 128'(ia.io_out_exceptionFlags), 128'(e.flags));
                chk("out_tag",   128'(ia.io_out_tag), 128'(e.tag));
                pops_a++;
            end
        end
        prev_stall = ia.io_out_valid && !ia.io_out_ready;
        prev_bits  = ia.io_out_bits;
        prev_flags = ia.io_out_exceptionFlags;
        prev_tag   = ia.io_out_tag;
        if (ia.io_in_valid && ia.io_in_ready) q_a.push_back(pend);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain_a();
        ia.io_in_valid  = 1'b0;
        ia.io_out_ready = 1'b1;
        for (int i = 0; i < 20 && q_a.size() > 0; i++) cycle_a();
        chk("drain_empty", 128'(q_a.size()), 128'd0);
    endtask

    task automatic send_a(input logic sgn, input logic [AI-1:0] bits, input logic [2:0] rm,
                          input logic [TW-1:0] tag, input logic [127:0] ebits, input logic [4:0] eflags);
        ia.io_in_valid        = 1'b1;
        ia.io_in_signedIn     = sgn;
        ia.io_in_bits         = bits;
        ia.io_in_roundingMode = rm;
        ia.io_in_tag          = tag;
        ia.io_out_ready       = 1'b1;
        pend = '{bits: ebits, flags: eflags, tag: tag};
        cycle_a();
        ia.io_in_valid = 1'b0;
    endtask

    task automatic rand_in_a(input logic [TW-1:0] tag);
        logic inx;
        logic [AI-1:0] b;
        b = {$urandom, $urandom};
        b = b >> $urandom_range(0, 63);
        ia.io_in_signedIn     = 1'($urandom_range(0, 1));
        ia.io_in_bits         = b;
        ia.io_in_roundingMode = 3'($urandom_range(0, 7));
        ia.io_in_tag          = tag;
        pend.bits  = ref_rec(AI, AE, AS, ia.io_in_signedIn, 128'(b), ia.io_in_roundingMode, inx);
        pend.flags = {4'b0000, inx};
        pend.tag   = tag;
    endtask

    task automatic b_one(input logic sgn, input logic [BI-1:0] bits, input logic [2:0] rm,
                         input logic [TW-1:0] tag);
        logic inx;
        logic [127:0] eb;
        eb = ref_rec(BI, BE, BS, sgn, 128'(bits), rm, inx);
        ib.io_in_valid        = 1'b1;
        ib.io_in_signedIn     = sgn;
        ib.io_in_bits         = bits;
        ib.io_in_roundingMode = rm;
        ib.io_in_tag          = tag;
        ib.io_out_ready       = 1'b1;
        #1 chk("b_in_ready", 128'(ib.io_in_ready), 128'd1);
        @(posedge clk); @(negedge clk);
        ib.io_in_valid = 1'b0;
        chk("b_lat1", 128'(ib.io_out_valid), 128'd0);
        @(posedge clk); @(negedge clk);
        chk("b_valid", 128'(ib.io_out_valid), 128'd1);
        chk("b_bits",  128'(ib.io_out_bits), eb);
        chk("b_flags", 128'(ib.io_out_exceptionFlags), 128'({4'b0000, inx}));
        chk("b_tag",   128'(ib.io_out_tag), 128'(tag));
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        ia.io_in_valid = 1'b1; ia.io_in_signedIn = 1'b0; ia.io_in_bits = 64'd7;
        ia.io_in_roundingMode = 3'd0; ia.io_in_tag = 4'd3; ia.io_out_ready = 1'b1;
        ib.io_in_valid = 1'b1; ib.io_in_signedIn = 1'b0; ib.io_in_bits = 32'd9;
        ib.io_in_roundingMode = 3'd0; ib.io_in_tag = 4'd3; ib.io_out_ready = 1'b1;
        pend = '0;
        repeat (3) begin @(posedge clk); end
        @(negedge clk);
        chk("rst_valid", 128'(ia.io_out_valid), 128'd0);
        chk("rst_bits",  128'(ia.io_out_bits), 128'd0);
        chk("rst_flags", 128'(ia.io_out_exceptionFlags), 128'd0);
        chk("rst_tag",   128'(ia.io_out_tag), 128'd0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        ia.io_in_valid = 1'b0;
        ib.io_in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("post_rst_ready", 128'(ia.io_in_ready), 128'd1);
        chk("rst_no_accept", 128'(ia.io_out_valid), 128'd0);
        @(posedge clk); @(negedge clk);
        chk("rst_no_accept2", 128'(ia.io_out_valid), 128'd0);

        // Exact two-cycle latency for the value one.
        ia.io_in_valid = 1'b1; ia.io_in_signedIn = 1'b0; ia.io_in_bits = 64'd1;
        ia.io_in_roundingMode = 3'd0; ia.io_in_tag = 4'h5; ia.io_out_ready = 1'b1;
        pend = '{bits: 128'h0_8000000000000000, flags: 5'h00, tag: 4'h5};
        cycle_a();
        ia.io_in_valid = 1'b0;
        chk("lat_cycle1", 128'(ia.io_out_valid), 128'd0);
        cycle_a();
        chk("lat_cycle2", 128'(ia.io_out_valid), 128'd1);
        drain_a();

        send_a(1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd0, 4'h1, 128'h1_8000000000000000, 5'h00);
        send_a(1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd0, 4'h2, 128'h0_8400000000000000, 5'h01);
        send_a(1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 4'h3, 128'h0_83FFFFFFFFFFFFFF, 5'h01);
        send_a(1'b0, 64'h0020000000000001, 3'd0, 4'h4, 128'h0_8350000000000000, 5'h01);
        send_a(1'b0, 64'h0020000000000001, 3'd4, 4'h5, 128'h0_8350000000000001, 5'h01);
        send_a(1'b0, 64'h0020000000000001, 3'd3, 4'h6, 128'h0_8350000000000001, 5'h01);
        send_a(1'b0, 64'h0020000000000001, 3'd2, 4'h7, 128'h0_8350000000000000, 5'h01);
        send_a(1'b1, 64'h0000000000000000, 3'd3, 4'h8, 128'h0, 5'h00);
        send_a(1'b1, 64'h8000000000000000, 3'd0, 4'h9, 128'h1_83F0000000000000, 5'h00);
        drain_a();

        // Random stream with a randomly stalling consumer.
        for (int c = 0; c < 500; c++) begin
            ia.io_in_valid  = ($urandom_range(0, 3) != 0);
            ia.io_out_ready = 1'($urandom_range(0, 1));
            rand_in_a(TW'(c));
            cycle_a();
        end
        drain_a();

        // Full rate: one result per cycle once the pipe has filled.
        pops_a = 0;
        for (int c = 0; c < 100; c++) begin
            ia.io_in_valid  = 1'b1;
            ia.io_out_ready = 1'b1;
            rand_in_a(TW'(c));
            cycle_a();
        end
        chk("throughput", 128'(pops_a), 128'd98);
        drain_a();

        // Reset with two requests in flight on instance A.
        for (int c = 0; c < 2; c++) begin
            ia.io_in_valid = 1'b1;
            ia.io_out_ready = 1'b1;
            rand_in_a(TW'(c));
            cycle_a();
        end
        rst_a_n = 1'b0;
        ia.io_in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        q_a.delete();
        prev_stall = 1'b0;
        chk("flush_valid", 128'(ia.io_out_valid), 128'd0);
        chk("flush_bits",  128'(ia.io_out_bits), 128'd0);
        rst_a_n = 1'b1;
        ia.io_in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); @(negedge clk);
            chk("flush_quiet", 128'(ia.io_out_valid), 128'd0);
        end
        send_a(1'b0, 64'd1, 3'd0, 4'hA, 128'h0_8000000000000000, 5'h00);
        drain_a();

        // Narrow instance: random conversions then the same reset flush.
        b_one(1'b1, 32'h80000000, 3'd0, 4'h1);
        b_one(1'b0, 32'hFFFFFFFF, 3'd0, 4'h2);
        b_one(1'b0, 32'h00000000, 3'd0, 4'h3);
        for (int c = 0; c < 12; c++) begin
            b_one(1'($urandom_range(0, 1)), $urandom >> $urandom_range(0, 31),
                  3'($urandom_range(0, 7)), TW'(c));
        end
        ib.io_in_valid = 1'b1; ib.io_in_bits = 32'h12345679; ib.io_out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        ib.io_in_bits = 32'h0000ABCD;
        @(posedge clk); @(negedge clk);
        rst_b_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_b_n = 1'b1;
        ib.io_in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); @(negedge clk);
            chk("b_flush_quiet", 128'(ib.io_out_valid), 128'd0);
        end
        b_one(1'b0, 32'd1, 3'd0, 4'hC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
